// File: rtl/uart_cmd_tx_if.sv
// Host-side handshake bundle for uart_cmd_tx: request/operands in, status and serial line out.
// The master drives requests; the slave (the serializer) answers with BUSY/DONE/UART_TX.
interface uart_cmd_tx_if #(
  parameter int ADDR_BYTES = 4,
  parameter int SIZE_BYTES = 4
);
  logic                    START;
  logic                    RW;
  logic [8*ADDR_BYTES-1:0] ADDR;
  logic [8*SIZE_BYTES-1:0] SIZE;
  logic                    BUSY;
  logic                    DONE;
  logic                    UART_TX;

  modport master (output START, RW, ADDR, SIZE, input BUSY, DONE, UART_TX);
  modport slave  (input START, RW, ADDR, SIZE, output BUSY, DONE, UART_TX);
endinterface

// File: rtl/uart_cmd_tx.sv
// UART command serializer: one START emits 'a'+addr, 'l'+size, then 'w'/'r', with idle gaps.
// Define UART_CMD_TX_PARITY_EN to append an even-parity bit after data[7] of every frame.
module uart_cmd_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int ADDR_BYTES   = 4,
  parameter int SIZE_BYTES   = 4,
  parameter int GAP_BITS     = 40,
  parameter int GUARD_BITS   = 2
) (
  input logic BUS_CLK,
  input logic BUS_RST,
  uart_cmd_tx_if.slave bus
);

`ifdef UART_CMD_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 2*GUARD_BITS + 10 + PAR_BITS;
  localparam int MAX_BITS   = (GAP_BITS > FRAME_BITS) ? GAP_BITS : FRAME_BITS;
  localparam int BW         = $clog2(MAX_BITS + 1);
  localparam int DW         = $clog2(CLKS_PER_BIT + 1);
  localparam int DATA_LO    = GUARD_BITS + 1;
  localparam int DATA_HI    = GUARD_BITS + 8;

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_cmd_tx: CLKS_PER_BIT must be >= 1");
  end
  if (ADDR_BYTES < 1 || ADDR_BYTES > 8) begin : g_bad_addr
    $error("uart_cmd_tx: ADDR_BYTES must be in 1..8");
  end
  if (SIZE_BYTES < 1 || SIZE_BYTES > 8) begin : g_bad_size
    $error("uart_cmd_tx: SIZE_BYTES must be in 1..8");
  end
  if (GAP_BITS < 1 || GUARD_BITS < 0) begin : g_bad_gap
    $error("uart_cmd_tx: GAP_BITS must be >= 1 and GUARD_BITS >= 0");
  end

  typedef enum logic [3:0] {
    IDLE, GAP0, CMD_A, ADDR_B, GAP1, CMD_L, SIZE_B, GAP2, CMD_OP, GAP3
  } state_t;

  state_t                  state, state_next;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt, bit_next;
  logic [2:0]              idx, idx_next;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [8*SIZE_BYTES-1:0] size_q;
  logic                    rw_q;
  logic [7:0]              data_sr;
  logic [7:0]              load_byte;
  logic                    tick, byte_state, next_byte_state, last_bit;
  logic                    shift_en, load_en, tx_d, tx_q, done_q;
`ifdef UART_CMD_TX_PARITY_EN
  logic                    parity_q;
`endif

  assign tick            = (div_cnt == DW'(CLKS_PER_BIT - 1));
  assign byte_state      = state inside {CMD_A, ADDR_B, CMD_L, SIZE_B, CMD_OP};
  assign next_byte_state = state_next inside {CMD_A, ADDR_B, CMD_L, SIZE_B, CMD_OP};
  assign last_bit        = byte_state ? (bit_cnt == BW'(FRAME_BITS - 1))
                                      : (bit_cnt == BW'(GAP_BITS - 1));
  assign shift_en        = tick && byte_state &&
                           (bit_cnt >= BW'(DATA_LO)) && (bit_cnt <= BW'(DATA_HI));
  assign load_en         = tick && last_bit && next_byte_state;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    idx_next   = idx;
    case (state)
      IDLE:   if (bus.START) state_next = GAP0;
      GAP0:   if (tick && last_bit) state_next = CMD_A;
      CMD_A:  if (tick && last_bit) state_next = ADDR_B;
      ADDR_B: if (tick && last_bit && idx == 3'(ADDR_BYTES - 1)) state_next = GAP1;
      GAP1:   if (tick && last_bit) state_next = CMD_L;
      CMD_L:  if (tick && last_bit) state_next = SIZE_B;
      SIZE_B: if (tick && last_bit && idx == 3'(SIZE_BYTES - 1)) state_next = GAP2;
      GAP2:   if (tick && last_bit) state_next = CMD_OP;
      CMD_OP: if (tick && last_bit) state_next = GAP3;
      GAP3:   if (tick && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state == IDLE) begin
      bit_next = '0;
      idx_next = '0;
    end else if (tick) begin
      bit_next = last_bit ? '0 : bit_cnt + 1'b1;
      if (last_bit && (state == ADDR_B || state == SIZE_B))
        idx_next = (state_next == state) ? idx + 3'd1 : 3'd0;
    end
  end

  // Line level is computed for the upcoming bit so the registered UART_TX lines up with the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_next)
      CMD_A:   load_byte = 8'h61;
      ADDR_B:  load_byte = addr_q[{idx_next, 3'b000} +: 8];
      CMD_L:   load_byte = 8'h6C;
      SIZE_B:  load_byte = size_q[{idx_next, 3'b000} +: 8];
      CMD_OP:  load_byte = rw_q ? 8'h72 : 8'h77;
      default: load_byte = 8'h00;
    endcase
    if (next_byte_state) begin
      if (bit_next == BW'(GUARD_BITS))
        tx_d = 1'b0;
      else if (bit_next >= BW'(DATA_LO) && bit_next <= BW'(DATA_HI))
        tx_d = shift_en ? data_sr[1] : data_sr[0];
`ifdef UART_CMD_TX_PARITY_EN
      else if (bit_next == BW'(DATA_HI + 1))
        tx_d = parity_q;
`endif
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      rw_q     <= 1'b0;
      data_sr  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_CMD_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      bit_cnt <= bit_next;
      idx     <= idx_next;
      tx_q    <= tx_d;
      done_q  <= (state == GAP3) && tick && last_bit;
      if (state == IDLE && bus.START) begin
        addr_q <= bus.ADDR;
        size_q <= bus.SIZE;
        rw_q   <= bus.RW;
      end
      if (load_en) begin
        data_sr  <= load_byte;
`ifdef UART_CMD_TX_PARITY_EN
        parity_q <= ^load_byte;
`endif
      end else if (shift_en) begin
        data_sr <= {1'b0, data_sr[7:1]};
      end
    end
  end

  assign bus.BUSY    = (state != IDLE);
  assign bus.DONE    = done_q;
  assign bus.UART_TX = tx_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx: two configurations, line waveform and bytes compared
// against a frame-level model built from the protocol rules.
module tb_uart_cmd_tx;

  localparam int GAP    = 40;
  localparam int G      = 2;
`ifdef UART_CMD_TX_PARITY_EN
  localparam int P      = 1;
`else
  localparam int P      = 0;
`endif
  localparam int F      = 2*G + 10 + P;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_tx_if #(.ADDR_BYTES(4), .SIZE_BYTES(4)) bus0 ();
  uart_cmd_tx_if #(.ADDR_BYTES(2), .SIZE_BYTES(1)) bus1 ();

  uart_cmd_tx #(.CLKS_PER_BIT(1)) dut0 (
    .BUS_CLK(clk), .BUS_RST(rst), .bus(bus0)
  );
  uart_cmd_tx #(.CLKS_PER_BIT(4), .ADDR_BYTES(2), .SIZE_BYTES(1)) dut1 (
    .BUS_CLK(clk), .BUS_RST(rst), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;
  bit         line_q[$];
  bit         exp_line[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  int busy_len, done_mid, done_end, first_start;

  task automatic drive(input int sel, input logic s, input logic [63:0] a,
                       input logic [63:0] sz, input logic rw);
    if (sel == 0) begin
      bus0.START = s; bus0.ADDR = a[31:0]; bus0.SIZE = sz[31:0]; bus0.RW = rw;
    end else begin
      bus1.START = s; bus1.ADDR = a[15:0]; bus1.SIZE = sz[7:0]; bus1.RW = rw;
    end
  endtask

  task automatic set_start(input int sel, input logic s);
    if (sel == 0) bus0.START = s;
    else          bus1.START = s;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? bus0.UART_TX : bus1.UART_TX;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.BUSY : bus1.BUSY;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? bus0.DONE : bus1.DONE;
  endfunction

  // Reference model: the ideal line, one entry per clock, straight from the framing rules.
  task automatic push_bits(input bit v, input int n, input int cpb);
    repeat (n*cpb) exp_line.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] b, input int cpb);
    push_bits(1'b1, G, cpb);
    push_bits(1'b0, 1, cpb);
    for (int j = 0; j < 8; j++) push_bits(b[j], 1, cpb);
`ifdef UART_CMD_TX_PARITY_EN
    push_bits(^b, 1, cpb);
`endif
    push_bits(1'b1, 1, cpb);
    push_bits(1'b1, G, cpb);
    exp_bytes.push_back(b);
  endtask

  task automatic build_expected(input int cpb, input int ab, input int sb,
                                input logic [63:0] a, input logic [63:0] sz, input logic rw);
    exp_line = {};
    exp_bytes = {};
    push_bits(1'b1, GAP, cpb);
    push_frame(8'h61, cpb);
    for (int i = 0; i < ab; i++) push_frame(a[8*i +: 8], cpb);
    push_bits(1'b1, GAP, cpb);
    push_frame(8'h6C, cpb);
    for (int i = 0; i < sb; i++) push_frame(sz[8*i +: 8], cpb);
    push_bits(1'b1, GAP, cpb);
    push_frame(rw ? 8'h72 : 8'h77, cpb);
    push_bits(1'b1, GAP, cpb);
  endtask

  // Independent UART receiver over the captured samples (mid-bit sampling).
  task automatic decode(input string name, input int cpb);
    int i;
    int flen;
    logic [7:0] b;
    i = 0;
    flen = cpb*(10 + P);
    got_bytes = {};
    first_start = -1;
    while (i < line_q.size()) begin
      if (line_q[i] == 1'b0) begin
        if (i + flen > line_q.size()) break;
        if (first_start < 0) first_start = i;
        for (int j = 0; j < 8; j++) b[j] = line_q[i + cpb*(1+j) + cpb/2];
`ifdef UART_CMD_TX_PARITY_EN
        checks++;
        if (line_q[i + cpb*9 + cpb/2] !== ^b) begin
          errors++;
          $display("[TB] FAIL %s parity byte %02h got %0b exp %0b", name, b,
                   line_q[i + cpb*9 + cpb/2], ^b);
        end
`endif
        checks++;
        if (line_q[i + cpb*(9+P) + cpb/2] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s stop bit of byte %02h got 0 exp 1", name, b);
        end
        got_bytes.push_back(b);
        i += flen;
      end else begin
        i++;
      end
    end
  endtask

  // Waits for the accept edge, then records the line while BUSY is high.
  task automatic capture(input int sel, input int inject_at, input logic [63:0] inj_addr,
                         input int b2b, input logic [63:0] nxt_addr,
                         input logic [63:0] nxt_size, input logic nxt_rw);
    bit ended;
    ended = 1'b0;
    line_q = {};
    busy_len = 0;
    done_mid = 0;
    done_end = 0;
    @(posedge clk);
    for (int k = 0; k < BUDGET && !ended; k++) begin
      @(negedge clk);
      if (k == 0) set_start(sel, 1'b0);
      if (k == inject_at) drive(sel, 1'b1, inj_addr, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      if (k == inject_at + 1) set_start(sel, 1'b0);
      if (busy_of(sel)) begin
        line_q.push_back(tx_of(sel));
        busy_len++;
        if (done_of(sel)) done_mid++;
      end else begin
        done_end = done_of(sel);
        if (b2b != 0) drive(sel, 1'b1, nxt_addr, nxt_size, nxt_rw);
        ended = 1'b1;
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout busy still high after %0d cycles", BUDGET);
    end
  endtask

  task automatic verify(input string name, input int cpb, input int ab, input int sb,
                        input logic [63:0] a, input logic [63:0] sz, input logic rw);
    int t_exp;
    int mism;
    build_expected(cpb, ab, sb, a, sz, rw);
    decode(name, cpb);
    t_exp = (4*GAP + (3 + ab + sb)*F) * cpb;
    checks++;
    if (busy_len !== t_exp) begin
      errors++;
      $display("[TB] FAIL %s busy_len got %0d exp %0d", name, busy_len, t_exp);
    end
    checks++;
    if (done_end !== 1 || done_mid !== 0) begin
      errors++;
      $display("[TB] FAIL %s done pulse got end=%0d mid=%0d exp end=1 mid=0",
               name, done_end, done_mid);
    end
    mism = 0;
    for (int i = 0; i < line_q.size() && i < exp_line.size(); i++)
      if (line_q[i] !== exp_line[i]) mism++;
    checks++;
    if (mism != 0 || line_q.size() != exp_line.size()) begin
      errors++;
      $display("[TB] FAIL %s waveform got %0d bad clocks len %0d exp 0 bad len %0d",
               name, mism, line_q.size(), exp_line.size());
    end
    checks++;
    if (first_start !== (GAP + G)*cpb) begin
      errors++;
      $display("[TB] FAIL %s first start bit got clock %0d exp %0d",
               name, first_start, (GAP + G)*cpb);
    end
    checks++;
    if (got_bytes.size() !== exp_bytes.size()) begin
      errors++;
      $display("[TB] FAIL %s byte count got %0d exp %0d", name, got_bytes.size(),
               exp_bytes.size());
    end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin
        errors++;
        $display("[TB] FAIL %s byte[%0d] got %02h exp %02h", name, i, got_bytes[i],
                 exp_bytes[i]);
      end
    end
  endtask

  task automatic check_idle(input string name, input int sel);
    checks++;
    if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 || done_of(sel) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s got tx=%0b busy=%0b done=%0b exp tx=1 busy=0 done=0",
               name, tx_of(sel), busy_of(sel), done_of(sel));
    end
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 64'h0, 64'h0, 1'b0);
    drive(1, 1'b0, 64'h0, 64'h0, 1'b0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_dut0", 0);
    check_idle("reset_dut1", 1);
    set_start(0, 1'b1);
    set_start(1, 1'b1);
    repeat (3) @(negedge clk);
    check_idle("reset_start_dut0", 0);
    check_idle("reset_start_dut1", 1);
    set_start(0, 1'b0);
    set_start(1, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("after_release_dut0", 0);
    check_idle("after_release_dut1", 1);
  endtask

  task automatic test_write;
    @(negedge clk);
    drive(0, 1'b1, 64'h0000_1000, 64'h0000_0004, 1'b0);
    capture(0, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
    verify("write", 1, 4, 4, 64'h0000_1000, 64'h0000_0004, 1'b0);
  endtask

  task automatic test_read;
    @(negedge clk);
    drive(1, 1'b1, 64'hBEEF, 64'h10, 1'b1);
    capture(1, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
    verify("read", 4, 2, 1, 64'hBEEF, 64'h10, 1'b1);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(0, 1'b1, 64'h0102_0304, 64'h0000_0100, 1'b1);
    capture(0, 100, 64'hDEAD_BEEF, 1, 64'h2, 64'h8, 1'b0);
    verify("busy_reject", 1, 4, 4, 64'h0102_0304, 64'h0000_0100, 1'b1);
    capture(0, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
    verify("back_to_back", 1, 4, 4, 64'h2, 64'h8, 1'b0);
  endtask

  task automatic test_reset_midop;
    int target;
    int dones;
    target = GAP + 2*F + G + 3;
    dones = 0;
    @(negedge clk);
    drive(0, 1'b1, 64'h1122_0044, 64'h0000_0020, 1'b0);
    @(posedge clk);
    for (int k = 0; k <= target; k++) begin
      @(negedge clk);
      if (k == 0) set_start(0, 1'b0);
      if (done_of(0)) dones++;
    end
    checks++;
    if (tx_of(0) !== 1'b0 || busy_of(0) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_precond got tx=%0b busy=%0b exp tx=0 busy=1",
               tx_of(0), busy_of(0));
    end
    rst = 1'b1;
    #1;
    check_idle("midop_async", 0);
    repeat (3) begin
      @(negedge clk);
      if (done_of(0)) dones++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_of(0) || busy_of(0) || !tx_of(0)) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("[TB] FAIL midop_quiet got %0d bad cycles exp 0", dones);
    end
    drive(0, 1'b1, 64'h8765_4321, 64'h0000_0040, 1'b1);
    capture(0, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
    verify("after_midop", 1, 4, 4, 64'h8765_4321, 64'h0000_0040, 1'b1);
  endtask

  task automatic test_random;
    logic [63:0] a, sz;
    logic rw;
    for (int n = 0; n < 4; n++) begin
      a  = {$urandom, $urandom};
      sz = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (n % 2 == 0) begin
        drive(0, 1'b1, a, sz, rw);
        capture(0, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
        verify("random_dut0", 1, 4, 4, {32'h0, a[31:0]}, {32'h0, sz[31:0]}, rw);
      end else begin
        drive(1, 1'b1, a, sz, rw);
        capture(1, -10, 64'h0, 0, 64'h0, 64'h0, 1'b0);
        verify("random_dut1", 4, 2, 1, {48'h0, a[15:0]}, {56'h0, sz[7:0]}, rw);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
